// File: rtl/mips_pkg.sv
// Shared MIPS definitions: CPU opcode/funct constants, HI/LO unit op codes and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_pkg;

    // CPU encodings for the HI/LO instruction group (R-type, opcode SPECIAL).
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;

    // Operation select for mips_muldiv. Bit 1 set on 2/3 means divide, bit 0 set means unsigned.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Only the signed arithmetic ops take operand magnitudes and need sign correction.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative datapath: radix-2 shift-add multiply / restoring divide on unsigned magnitudes.
// Latency: one step per cycle while step_i is high; WIDTH steps give the full result.
// Backpressure: none; the controlling FSM decides when to load and step.
// Ports: load_i/ld_sh_i/ld_opnd_i seed the registers, step_i/is_div_i advance one iteration,
//        acc_o/sh_o expose {high,low} product or {remainder,quotient}.
module muldiv_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] ld_sh_i,
    input  logic [WIDTH-1:0] ld_opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] sh_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   add;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        acc_d   = acc_q;
        sh_d    = sh_q;
        opnd_d  = opnd_q;
        sum     = {1'b0, acc_q} + {1'b0, opnd_q};
        add     = sh_q[0] ? sum : {1'b0, acc_q};
        shifted = {acc_q, sh_q[WIDTH-1]};
        // When shifted >= divisor the true difference is below the divisor, so it fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - opnd_q;

        if (load_i) begin
            acc_d  = '0;
            sh_d   = ld_sh_i;
            opnd_d = ld_opnd_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // Restoring step: shift next dividend bit into the partial remainder, try subtract.
                if (shifted >= {1'b0, opnd_q}) begin
                    acc_d = diff;
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Shift-add step: multiplier LSB gates the add, then {acc,sh} shifts right by one.
                acc_d = add[WIDTH:1];
                sh_d  = {add[0], sh_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sh_q   <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc_o = acc_q;
    assign sh_o  = sh_q;

endmodule

// File: rtl/mips_muldiv.sv
// MIPS HI/LO unit: iterative MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO.
// Latency: fixed, done is high in the cycle ending WIDTH+2 edges after start is accepted.
// Backpressure: no queueing; start is taken only in IDLE, caller stalls while busy is high.
// Ports: clk/rst_n; start/op/a/b request; flush aborts CALC/FIX; busy, done, dbz status; hi/lo.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;      // result sign flips (operand signs differ)
    logic             a_neg_q, a_neg_d;  // remainder follows dividend sign
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] ld_sh, ld_opnd;
    logic [WIDTH-1:0] acc, sh;
    logic             load, step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign sgn   = op_is_signed(op);
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    // Multiply shifts the multiplier (b) through sh; divide shifts the dividend (a) through sh.
    assign ld_sh   = op[1] ? a_mag : b_mag;
    assign ld_opnd = op[1] ? b_mag : a_mag;

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .step_i    (step),
        .is_div_i  (is_div_q),
        .ld_sh_i   (ld_sh),
        .ld_opnd_i (ld_opnd),
        .acc_o     (acc),
        .sh_o      (sh)
    );

    // Sign correction, evaluated in FIX and committed on the FIX->DONE edge.
    // A zero divisor forces an all-ones quotient; the remainder is already |a| with a's sign, i.e. a.
    always_comb begin
        prod = {acc, sh};
        if (neg_q) prod = -prod;
        quo  = dbz_q ? '1 : (neg_q ? -sh : sh);
        rem  = a_neg_q ? -acc : acc;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        load     = 1'b0;
        step     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (muldiv_op_e'(op))
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            load     = 1'b1;
                            state_d  = ST_CALC;
                            cnt_d    = CNT_W'(WIDTH);
                            is_div_d = op[1];
                            neg_d    = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            a_neg_d  = sgn && a[WIDTH-1];
                            dbz_d    = op[1] && (b == '0);
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;  // result already committed; flush is irrelevant here
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done = (state_q == ST_DONE);
    assign dbz  = (state_q == ST_DONE) && dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width (legal: even values 8..64).
REQ-002 The module SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the width of the iteration counter.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-007 a  input  WIDTH  rs operand (multiplicand/dividend/move source).
REQ-008 b  input  WIDTH  rt operand (multiplier/divisor).
REQ-009 flush  input  1  abort of the in-flight operation.
REQ-010 busy  output  1  high while an operation is in flight.
REQ-011 done  output  1  one-cycle pulse when hi/lo take a MULT/DIV result.
REQ-012 dbz  output  1  divide-by-zero flag, valid only while done is high.
REQ-013 hi  output  WIDTH  architectural HI register.
REQ-014 lo  output  WIDTH  architectural LO register.

Function
REQ-015 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-016 In IDLE, start with op 0-3 SHALL latch |a|, |b|, op and sign info, and enter CALC with counter = WIDTH; busy SHALL rise in the next cycle.
REQ-017 The magnitude of an operand SHALL be taken only for op 0 and op 2 (signed); op 1 and op 3 SHALL use the raw bits.
REQ-018 In CALC, each cycle SHALL perform one shift-add step (multiply) or one restoring subtract-shift step (divide) and decrement the counter; counter reaching 1 SHALL move to FIX.
REQ-019 FIX SHALL apply sign correction:
  - signed product negated (2*WIDTH bits) when operand signs differ;
  - signed quotient negated when signs differ;
  - remainder takes the sign of the dividend.
REQ-020 On the FIX->DONE transition, hi/lo SHALL load the result: multiply {hi,lo} = 2*WIDTH product; divide lo = quotient, hi = remainder.
REQ-021 In DONE, done SHALL be high for exactly one cycle, busy SHALL be low, and the state SHALL return to IDLE.
REQ-022 Latency SHALL be fixed: done high exactly WIDTH+2 cycles after the edge that accepted start, independent of operand values.
REQ-023 Signed divide SHALL truncate toward zero; MIN / -1 SHALL yield lo = MIN and hi = 0 (wrap, no trap).
REQ-024 A divisor of 0 SHALL yield lo = all ones and hi = a, with dbz = 1 alongside done; the full latency SHALL still apply.
REQ-025 start with op 4 (MTHI) or op 5 (MTLO) in IDLE SHALL write a to hi or lo at that edge, stay in IDLE, and assert neither busy nor done.
REQ-026 start with op 6-7 SHALL be ignored.
REQ-027 start in any state other than IDLE SHALL be ignored; there is no queueing.
REQ-028 start and flush in the same IDLE cycle: flush SHALL win and nothing is accepted.
REQ-029 flush in CALC or FIX SHALL return to IDLE at the next edge, leave hi/lo unchanged and produce no done.
REQ-030 flush in DONE SHALL have no effect; the result is already committed.
REQ-031 hi and lo SHALL change only per REQ-020 and REQ-025.

Reset
REQ-032 While rst_n is low, the block SHALL asynchronously hold the following values:
  - state IDLE;
  - hi = 0 and lo = 0;
  - busy, done and dbz = 0;
  - counter and datapath registers 0.
REQ-033 Reset asserted mid-operation SHALL discard the operation with no done pulse.
REQ-034 After rst_n rises, the first edge SHALL be able to accept start.

Structure
REQ-035 The op encodings and FSM state encodings SHALL live in the shared package mips_pkg, alongside the CPU opcode/funct constants.
REQ-036 The iterative datapath (accumulator, shift register, add/subtract) SHALL be one sub-module, muldiv_datapath, with the FSM and HI/LO held in mips_muldiv.
REQ-037 The top-level CPU SHALL replace its single-cycle HI/LO arithmetic with this block, stalling its Execute stage while busy is high.

Verification (WIDTH=32)
REQ-038 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-040 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=2 -> lo=3, hi=1.
REQ-041 DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, dbz=1.
REQ-042 MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy and done never high.
REQ-043 MULT started, flush at cycle 10, second start during the flush cycle -> no done, hi/lo unchanged, second start ignored.
REQ-044 MULT started, rst_n low at cycle 5 -> all outputs 0 immediately, no done.
